// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, state encoding and small block-building helpers
// for the SHA-256 message controller.
//   WORD_W / BLK_W / DIG_W  word, block and digest widths
//   SHA256_IV               initial hash value H0..H7, H0 in the top 32 bits
//   state_t                 controller FSM states
//   put_word                write word i of a 512-bit block (W0 at the top)
//   pad_last_word           terminate a partial final word with the 0x80 byte
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 512;
    localparam int DIG_W  = 256;

    localparam logic [DIG_W-1:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_START,
        ST_WAIT,
        ST_UPDATE,
        ST_OUT
    } state_t;

    function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0]  blk,
                                                  input logic [3:0]        i,
                                                  input logic [WORD_W-1:0] w);
        logic [BLK_W-1:0] r;
        r = blk;
        for (int k = 0; k < 16; k++) begin
            if (i == 4'(k)) r[BLK_W-1-WORD_W*k -: WORD_W] = w;
        end
        return r;
    endfunction

    // Keep bytes 0..n-1 (big-endian), put 0x80 in byte n, zero the rest.
    function automatic logic [WORD_W-1:0] pad_last_word(input logic [WORD_W-1:0] w,
                                                        input logic [1:0]        n);
        logic [WORD_W-1:0] r;
        case (n)
            2'd0:    r = 32'h8000_0000;
            2'd1:    r = {w[31:24], 24'h80_0000};
            2'd2:    r = {w[31:16], 16'h8000};
            default: r = {w[31:8],  8'h80};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_feedforward.sv
// sha256_feedforward: SHA-256 feed-forward, eight independent 32-bit lanes
// added modulo 2^32 (no carry between lanes).
//   h_in      current chaining value H0..H7
//   state_in  core working variables a..h after round 63
//   h_out     H + state, lane by lane
module sha256_feedforward
    import sha256_pkg::*;
(
    input  logic [DIG_W-1:0] h_in,
    input  logic [DIG_W-1:0] state_in,
    output logic [DIG_W-1:0] h_out
);

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign h_out[WORD_W*i +: WORD_W] = h_in[WORD_W*i +: WORD_W] + state_in[WORD_W*i +: WORD_W];
    end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl: packs a big-endian 32-bit word stream into 512-bit blocks,
// applies FIPS 180-4 padding, drives one compression core per block, chains
// the hash value and presents the final digest.
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_data/s_valid/s_ready         message word stream (first byte in [31:24])
//   s_last/s_nbytes                final word marker and its valid byte count
//   core_start/core_block/core_hin request to the compression core
//   core_done/core_state           core result (a..h before feed-forward)
//   digest/digest_valid/digest_ready  final hash handshake
//   busy                           a message is in progress
//   dbg_state                      current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold data stable while valid is high and not accepted;
// digest_valid stays high with a stable digest until digest_ready is seen.
module sha256_msg_ctrl
    import sha256_pkg::*;
#(
    parameter int               LEN_W = 64,
    parameter logic [DIG_W-1:0] IV    = SHA256_IV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [2:0]        s_nbytes,
    output logic              core_start,
    output logic [BLK_W-1:0]  core_block,
    output logic [DIG_W-1:0]  core_hin,
    input  logic              core_done,
    input  logic [DIG_W-1:0]  core_state,
    output logic [DIG_W-1:0]  digest,
    output logic              digest_valid,
    input  logic              digest_ready,
    output logic              busy,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;          // next word slot, 16 = block full
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [DIG_W-1:0]  h_q, h_d;
    logic [DIG_W-1:0]  digest_q, digest_d;
    logic [LEN_W-1:0]  bitlen_q, bitlen_d;
    logic              msg_open_q, msg_open_d;  // at least one word accepted
    logic              last_q, last_d;          // final word accepted, padding phase
    logic              pad_done_q, pad_done_d;  // 0x80 terminator written
    logic              len_done_q, len_done_d;  // length words written
    logic              s_ready_q, s_ready_d;
    logic              core_start_q, core_start_d;
    logic              digest_valid_q, digest_valid_d;
    logic              busy_q, busy_d;

    logic [DIG_W-1:0]  ff_sum;
    logic [63:0]       len64;
    logic [2:0]        nb_eff;

    sha256_feedforward u_ff (
        .h_in     (h_q),
        .state_in (core_state),
        .h_out    (ff_sum)
    );

    assign len64  = 64'(bitlen_q);
    // Short words are only meaningful on the last beat; elsewhere count 4 bytes.
    assign nb_eff = (s_last && (s_nbytes < 3'd4)) ? s_nbytes : 3'd4;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        blk_d          = blk_q;
        h_d            = h_q;
        digest_d       = digest_q;
        bitlen_d       = bitlen_q;
        msg_open_d     = msg_open_q;
        last_d         = last_q;
        pad_done_d     = pad_done_q;
        len_done_d     = len_done_q;
        digest_valid_d = digest_valid_q;

        case (state_q)
            ST_FILL: begin
                if (s_valid && s_ready_q) begin
                    msg_open_d = 1'b1;
                    bitlen_d   = bitlen_q + LEN_W'({nb_eff, 3'b000});
                    idx_d      = idx_q + 5'd1;
                    if (s_last) begin
                        blk_d      = put_word(blk_q, idx_q[3:0],
                                              (nb_eff == 3'd4) ? s_data
                                                               : pad_last_word(s_data, nb_eff[1:0]));
                        pad_done_d = (nb_eff != 3'd4);
                        last_d     = 1'b1;
                        state_d    = ST_PAD;
                    end else begin
                        blk_d = put_word(blk_q, idx_q[3:0], s_data);
                        if (idx_q == 5'd15) state_d = ST_START;
                    end
                end
            end
            ST_PAD: begin
                if (idx_q[4]) begin
                    // Block filled before the length fit; it continues in the next block.
                    state_d = ST_START;
                end else if (!pad_done_q) begin
                    blk_d      = put_word(blk_q, idx_q[3:0], 32'h8000_0000);
                    pad_done_d = 1'b1;
                    idx_d      = idx_q + 5'd1;
                end else if (idx_q == 5'd14) begin
                    blk_d      = put_word(put_word(blk_q, 4'd14, len64[63:32]), 4'd15, len64[31:0]);
                    len_done_d = 1'b1;
                    idx_d      = 5'd16;
                    state_d    = ST_START;
                end else begin
                    blk_d = put_word(blk_q, idx_q[3:0], '0);
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                h_d   = ff_sum;
                idx_d = '0;
                if (len_done_q) begin
                    digest_d       = ff_sum;
                    digest_valid_d = 1'b1;
                    state_d        = ST_OUT;
                end else if (last_q) begin
                    state_d = ST_PAD;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_OUT: begin
                if (digest_ready) begin
                    digest_valid_d = 1'b0;
                    h_d            = IV;
                    bitlen_d       = '0;
                    msg_open_d     = 1'b0;
                    last_d         = 1'b0;
                    pad_done_d     = 1'b0;
                    len_done_d     = 1'b0;
                    state_d        = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        // Outputs are registered from the next state so they line up with it.
        s_ready_d    = (state_d == ST_FILL);
        core_start_d = (state_d == ST_START);
        busy_d       = !((state_d == ST_FILL) && (idx_d == 5'd0) && !msg_open_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FILL;
            idx_q          <= '0;
            blk_q          <= '0;
            h_q            <= IV;
            digest_q       <= '0;
            bitlen_q       <= '0;
            msg_open_q     <= 1'b0;
            last_q         <= 1'b0;
            pad_done_q     <= 1'b0;
            len_done_q     <= 1'b0;
            s_ready_q      <= 1'b0;
            core_start_q   <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            blk_q          <= blk_d;
            h_q            <= h_d;
            digest_q       <= digest_d;
            bitlen_q       <= bitlen_d;
            msg_open_q     <= msg_open_d;
            last_q         <= last_d;
            pad_done_q     <= pad_done_d;
            len_done_q     <= len_done_d;
            s_ready_q      <= s_ready_d;
            core_start_q   <= core_start_d;
            digest_valid_q <= digest_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign core_start   = core_start_q;
    assign core_block   = blk_q;
    assign core_hin     = h_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule
